// File: rtl/coef_loader_pkg.sv
// Shared types and helpers for the coefficient loader.
package coef_loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StWait,
    StStart,
    StAck,
    StBusy
  } cl_state_t;

  function automatic int unsigned cl_beats(int unsigned in_w, int unsigned pin_w);
    return (in_w + pin_w - 1) / pin_w;
  endfunction

endpackage

// File: rtl/beat_packer.sv
// Assembles LSB-first pin beats into one IN_W word; word is valid alongside word_done.
module beat_packer
  import coef_loader_pkg::*;
#(
  parameter int unsigned IN_W  = 8,
  parameter int unsigned PIN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             beat_valid,
  input  logic [PIN_W-1:0] beat_data,
  output logic [IN_W-1:0]  word,
  output logic             word_done
);

  localparam int unsigned BEATS = cl_beats(IN_W, PIN_W);
  localparam int unsigned SR_W  = BEATS * PIN_W;
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [SR_W-1:0]  sr_q, sr_d, shifted, beat_ext;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_beat;

  always_comb begin
    // New beat enters at the top so the first beat ends up in the low bits.
    beat_ext  = SR_W'(beat_data) << (SR_W - PIN_W);
    shifted   = (sr_q >> PIN_W) | beat_ext;
    last_beat = (cnt_q == CNT_W'(BEATS - 1));
    word      = shifted[IN_W-1:0];
    word_done = beat_valid && last_beat && !clr;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    if (clr) begin
      sr_d  = '0;
      cnt_d = '0;
    end else if (beat_valid) begin
      sr_d  = shifted;
      cnt_d = last_beat ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/coef_loader.sv
// Coefficient loader: stages a frame from the pin bus, commits it atomically,
// pulses start_calc and tracks the core busy handshake with an ack timeout.
module coef_loader
  import coef_loader_pkg::*;
#(
  parameter int unsigned NUM_COEF = 2,
  parameter int unsigned IN_W     = 8,
  parameter int unsigned COEF_W   = 32,
  parameter int unsigned PIN_W    = 8,
  parameter bit          SIGNED   = 1'b0,
  parameter int unsigned ACK_TO   = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [PIN_W-1:0]           pin_data,
  input  logic                       pin_valid,
  output logic                       pin_ready,
  input  logic                       frame_clr,
  output logic [NUM_COEF*COEF_W-1:0] coef,
  output logic                       start_calc,
  input  logic                       core_busy,
  output logic                       ovf,
  output logic                       ack_err
);

  localparam int unsigned CC_W = (NUM_COEF > 1) ? $clog2(NUM_COEF) : 1;
  localparam int unsigned AC_W = $clog2(ACK_TO + 1);

  cl_state_t state_q, state_d;

  logic [CC_W-1:0]                  coef_cnt_q, coef_cnt_d;
  logic [NUM_COEF-1:0][IN_W-1:0]    stage_q, stage_d;
  logic [NUM_COEF*COEF_W-1:0]       coef_q, coef_d;
  logic [AC_W-1:0]                  ack_cnt_q, ack_cnt_d;
  logic                             start_q, ovf_q, ovf_d, ack_err_q, ack_err_d;

  logic            load_phase, abort, accept, frame_last, commit, word_done;
  logic [IN_W-1:0] word;

  assign load_phase = (state_q == StIdle) || (state_q == StLoad);
  assign abort      = frame_clr && (load_phase || (state_q == StWait));
  // frame_clr takes priority over a beat presented on the same edge.
  assign accept     = pin_valid && load_phase && !frame_clr;
  assign frame_last = word_done && (coef_cnt_q == CC_W'(NUM_COEF - 1));

  beat_packer #(
    .IN_W  (IN_W),
    .PIN_W (PIN_W)
  ) u_beat_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (abort),
    .beat_valid (accept),
    .beat_data  (pin_data),
    .word       (word),
    .word_done  (word_done)
  );

  always_comb begin
    state_d    = state_q;
    coef_cnt_d = coef_cnt_q;
    stage_d    = stage_q;
    coef_d     = coef_q;
    ack_cnt_d  = ack_cnt_q;
    ack_err_d  = ack_err_q;
    commit     = 1'b0;

    if (word_done) begin
      stage_d[coef_cnt_q] = word;
      coef_cnt_d = frame_last ? '0 : coef_cnt_q + CC_W'(1);
    end

    unique case (state_q)
      StIdle:  if (accept) state_d = frame_last ? StWait : StLoad;
      StLoad:  if (frame_last) state_d = StWait;
      StWait: begin
        if (!core_busy && !frame_clr) begin
          state_d = StStart;
          commit  = 1'b1;
        end
      end
      StStart: begin
        state_d   = StAck;
        ack_cnt_d = '0;
      end
      StAck: begin
        if (core_busy) begin
          state_d = StBusy;
        end else if (ack_cnt_q == AC_W'(ACK_TO - 1)) begin
          state_d   = StIdle;
          ack_err_d = 1'b1;
        end else begin
          ack_cnt_d = ack_cnt_q + AC_W'(1);
        end
      end
      StBusy:  if (!core_busy) state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (abort) begin
      state_d    = StIdle;
      coef_cnt_d = '0;
      stage_d    = '0;
    end

    if (commit) begin
      ack_err_d = 1'b0;
      for (int i = 0; i < NUM_COEF; i++) begin
        if (SIGNED) coef_d[i*COEF_W +: COEF_W] = COEF_W'($signed(stage_q[i]));
        else        coef_d[i*COEF_W +: COEF_W] = COEF_W'(stage_q[i]);
      end
    end

    ovf_d = ovf_q;
    if (frame_clr)                  ovf_d = 1'b0;
    else if (pin_valid && !load_phase) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      coef_cnt_q <= '0;
      stage_q    <= '0;
      coef_q     <= '0;
      ack_cnt_q  <= '0;
      start_q    <= 1'b0;
      ovf_q      <= 1'b0;
      ack_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      coef_cnt_q <= coef_cnt_d;
      stage_q    <= stage_d;
      coef_q     <= coef_d;
      ack_cnt_q  <= ack_cnt_d;
      start_q    <= (state_d == StStart);
      ovf_q      <= ovf_d;
      ack_err_q  <= ack_err_d;
    end
  end

  assign pin_ready  = load_phase;
  assign coef       = coef_q;
  assign start_calc = start_q;
  assign ovf        = ovf_q;
  assign ack_err    = ack_err_q;

endmodule

// File: tb/tb_coef_loader.sv
// Bench for coef_loader: phase-level model checked every cycle on the default
// instance, plus directed literal checks on a default and a signed 12-bit instance.
module tb_coef_loader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Default-parameter instance
  logic [7:0]  pin_data = '0;
  logic        pin_valid = 1'b0, frame_clr = 1'b0, core_busy = 1'b0;
  logic        pin_ready, start_calc, ovf, ack_err;
  logic [63:0] coef;

  // SIGNED=1, IN_W=12 instance
  logic [7:0]  s_pin_data = '0;
  logic        s_pin_valid = 1'b0, s_frame_clr = 1'b0, s_core_busy = 1'b0;
  logic        s_pin_ready, s_start_calc, s_ovf, s_ack_err;
  logic [63:0] s_coef;

  coef_loader u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pin_data   (pin_data),
    .pin_valid  (pin_valid),
    .pin_ready  (pin_ready),
    .frame_clr  (frame_clr),
    .coef       (coef),
    .start_calc (start_calc),
    .core_busy  (core_busy),
    .ovf        (ovf),
    .ack_err    (ack_err)
  );

  coef_loader #(
    .IN_W   (12),
    .SIGNED (1'b1)
  ) u_dut_s (
    .clk        (clk),
    .rst_n      (rst_n),
    .pin_data   (s_pin_data),
    .pin_valid  (s_pin_valid),
    .pin_ready  (s_pin_ready),
    .frame_clr  (s_frame_clr),
    .coef       (s_coef),
    .start_calc (s_start_calc),
    .core_busy  (s_core_busy),
    .ovf        (s_ovf),
    .ack_err    (s_ack_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b, expected %0b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Phase model: 0 = collecting beats, 1 = frame held, 2 = start pulse,
  // 3 = awaiting ack, 4 = core running.
  int         m_phase;
  int         m_ackwait;
  logic [7:0] m_beats[$];
  logic [31:0] m_coef[2];
  logic       m_ovf, m_ackerr;

  initial begin
    m_phase = 0; m_ackwait = 0; m_ovf = 0; m_ackerr = 0;
    m_coef[0] = '0; m_coef[1] = '0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_phase = 0; m_ackwait = 0; m_ovf = 0; m_ackerr = 0;
        m_coef[0] = '0; m_coef[1] = '0;
        m_beats.delete();
      end else begin
        if (frame_clr) m_ovf = 0;
        else if (pin_valid && m_phase != 0) m_ovf = 1;
        case (m_phase)
          0: begin
            if (frame_clr) m_beats.delete();
            else if (pin_valid) begin
              m_beats.push_back(pin_data);
              if (m_beats.size() == 2) m_phase = 1;
            end
          end
          1: begin
            if (frame_clr) begin
              m_beats.delete();
              m_phase = 0;
            end else if (!core_busy) begin
              for (int i = 0; i < 2; i++) m_coef[i] = {24'd0, m_beats[i]};
              m_beats.delete();
              m_ackerr = 0;
              m_phase = 2;
            end
          end
          2: begin
            m_phase = 3;
            m_ackwait = 0;
          end
          3: begin
            if (core_busy) m_phase = 4;
            else begin
              m_ackwait++;
              if (m_ackwait == 16) begin
                m_phase = 0;
                m_ackerr = 1;
              end
            end
          end
          default: if (!core_busy) m_phase = 0;
        endcase
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check("m_coef", coef, {m_coef[1], m_coef[0]});
      check1("m_start", start_calc, m_phase == 2);
      check1("m_ready", pin_ready, m_phase == 0);
      check1("m_ovf", ovf, m_ovf);
      check1("m_ack_err", ack_err, m_ackerr);
    end
  end

  initial begin
    repeat (3) tick();
    check1("rst_ready", pin_ready, 1'b1);
    check("rst_coef", coef, 64'd0);
    check1("rst_start", start_calc, 1'b0);
    check1("rst_ovf", ovf, 1'b0);
    check1("rst_s_ready", s_pin_ready, 1'b1);
    rst_n = 1'b1;

    // Signed 12-bit frame over two beats per coefficient
    s_pin_valid = 1'b1; s_pin_data = 8'h34; tick();
    s_pin_data = 8'hFA; tick();
    s_pin_data = 8'h01; tick();
    s_pin_data = 8'h00; tick();
    s_pin_valid = 1'b0; tick();
    check1("s_start", s_start_calc, 1'b1);
    check("s_coef", s_coef, 64'h00000001_FFFFFA34);
    check1("s_ovf", s_ovf, 1'b0);
    check1("s_ack_err", s_ack_err, 1'b0);
    tick();
    check1("s_start_end", s_start_calc, 1'b0);

    // Unsigned frame 0x85, 0x10
    pin_valid = 1'b1; pin_data = 8'h85; tick();
    pin_data = 8'h10; tick();
    pin_valid = 1'b0;
    check1("s1_no_start", start_calc, 1'b0);
    tick();
    check1("s1_start", start_calc, 1'b1);
    check("s1_coef", coef, 64'h00000010_00000085);
    check("model_c0", {32'd0, m_coef[0]}, 64'h85);
    check("model_c1", {32'd0, m_coef[1]}, 64'h10);
    tick();
    check1("s1_start_end", start_calc, 1'b0);
    tick(); tick();
    core_busy = 1'b1;
    repeat (10) tick();
    core_busy = 1'b0;
    tick(); tick();
    check1("s1_idle", pin_ready, 1'b1);

    // Busy held through WAIT
    core_busy = 1'b1;
    pin_valid = 1'b1; pin_data = 8'hA5; tick();
    pin_data = 8'h5A; tick();
    pin_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check1("hold_no_start", start_calc, 1'b0);
      check("hold_coef", coef, 64'h00000010_00000085);
    end
    core_busy = 1'b0; tick();
    check1("hold_start", start_calc, 1'b1);
    check("hold_coef_new", coef, 64'h0000005A_000000A5);
    core_busy = 1'b1; tick(); tick();
    pin_valid = 1'b1; pin_data = 8'h77; tick();
    pin_valid = 1'b0;
    check1("busy_ovf", ovf, 1'b1);
    check("busy_coef", coef, 64'h0000005A_000000A5);
    tick();
    core_busy = 1'b0; tick(); tick();
    check1("ovf_sticky", ovf, 1'b1);

    // Abort a partial frame, then load 0x11, 0x22; ack never arrives
    pin_valid = 1'b1; pin_data = 8'h99; tick();
    pin_valid = 1'b0; frame_clr = 1'b1; tick();
    frame_clr = 1'b0;
    check1("abort_ovf", ovf, 1'b0);
    pin_valid = 1'b1; pin_data = 8'h11; tick();
    pin_data = 8'h22; tick();
    pin_valid = 1'b0; tick();
    check1("abort_start", start_calc, 1'b1);
    check("abort_coef", coef, 64'h00000022_00000011);
    tick();
    repeat (15) tick();
    check1("to_pending", ack_err, 1'b0);
    tick();
    check1("to_ack_err", ack_err, 1'b1);
    check1("to_idle", pin_ready, 1'b1);
    pin_valid = 1'b1; pin_data = 8'h03; tick();
    pin_data = 8'h04; tick();
    pin_valid = 1'b0; tick();
    check1("to_clear", ack_err, 1'b0);
    check("to_coef", coef, 64'h00000004_00000003);
    tick();
    core_busy = 1'b1; tick(); tick();
    core_busy = 1'b0; tick(); tick();

    // Overrun in WAIT, then reset while start_calc is high
    core_busy = 1'b1;
    pin_valid = 1'b1; pin_data = 8'h55; tick();
    pin_data = 8'h66; tick();
    pin_data = 8'h77; tick();
    pin_valid = 1'b0;
    check1("wait_ovf", ovf, 1'b1);
    core_busy = 1'b0; tick();
    check1("rst2_start_pre", start_calc, 1'b1);
    check("rst2_coef_pre", coef, 64'h00000066_00000055);
    #2 rst_n = 1'b0;
    #1;
    check1("rst2_start", start_calc, 1'b0);
    check("rst2_coef", coef, 64'd0);
    check1("rst2_ovf", ovf, 1'b0);
    check1("rst2_ready", pin_ready, 1'b1);
    tick();
    rst_n = 1'b1;

    // Reset mid-LOAD discards the partial frame
    pin_valid = 1'b1; pin_data = 8'h12; tick();
    pin_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check1("rst3_ready", pin_ready, 1'b1);
    check("rst3_coef", coef, 64'd0);
    tick();
    rst_n = 1'b1;
    pin_valid = 1'b1; pin_data = 8'hAB; tick();
    pin_data = 8'hCD; tick();
    pin_valid = 1'b0; tick();
    check1("rst3_start", start_calc, 1'b1);
    check("rst3_coef_new", coef, 64'h000000CD_000000AB);
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
